uart_rx_frame_deserializer: RTL and testbench
=============================================

// Module: uart_rx_frame_deserializer
// PURPOSE
//  Parametrised UART RX deserializer with its own frame sequencer. Sits between the bit
//  sampler and the RX top level. Each strobed sample is placed into start/data/parity/stop
//  fields under an internal bit counter. A completed frame is delivered through a one-entry
//  valid/ready output register, with framing and overrun status.
// PARAMETERS
//  DATA_W    8   data bits per frame (5..9), sent LSB first
//  CNT_W     4   bit-counter width; must satisfy 2**CNT_W > DATA_W+3
// PORTS
//  clk           in   1       system clock
//  rst_n         in   1       asynchronous active-low reset
//  cfg_par_en    in   1       parity bit present; latched at frame start
//  cfg_par_odd   in   1       odd parity when 1, even when 0; latched at frame start
//  cfg_stop2     in   1       two stop bits when 1; latched at frame start
//  bit_strobe    in   1       one-cycle pulse: sampled_bit is valid this cycle
//  sampled_bit   in   1       majority-voted line sample from the sampler
//  frame_abort   in   1       synchronous abort: discard the partial frame, go to IDLE
//  data_out      out  DATA_W  held frame data
//  data_valid    out  1       data_out, framing_err and parity_err are valid
//  data_ready    in   1       consumer accepts when data_valid && data_ready
//  framing_err   out  1       start bit != 0 or any stop bit != 1 in the held frame
//  parity_err    out  1       parity mismatch in the held frame (see CONFIGURATION)
//  overrun       out  1       one-cycle pulse: a completed frame was dropped
//  busy          out  1       state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, shift reg=0. All outputs are 0, including data_out.
//  Action is taken only in cycles with bit_strobe=1. Other cycles hold state.
//  FSM states: IDLE, DATA, PARITY, STOP1, STOP2.
//   IDLE  : strobe with bit=0 -> DATA. Latch the cfg_* inputs, clear the counter.
//           strobe with bit=1 -> stay in IDLE (false start; nothing recorded).
//   DATA  : each strobe shifts the bit into shreg[DATA_W-1] and right-shifts, so the
//           first bit ends at [0]. Counter increments. After the DATA_W-th bit:
//           go to PARITY if par_en, else STOP1.
//   PARITY: the strobe stores the parity bit -> STOP1.
//   STOP1 : the strobe stores stop bit 1 -> STOP2 if stop2, else commit and go to IDLE.
//   STOP2 : the strobe stores stop bit 2 -> commit and go to IDLE.
//  Commit (the clock edge of the final stop strobe):
//   - Output register empty, or data_valid && data_ready in the same cycle:
//     load data_out, framing_err and parity_err; data_valid=1 on the next cycle.
//     Latency is 1 clk from the final stop strobe.
//   - Output register full and data_ready=0: the new frame is dropped, overrun=1 for one
//     cycle, and the held frame is unchanged.
//  framing_err: the frame is still delivered; the flag travels with the data.
//  Handshake: data_valid deasserts the cycle after acceptance unless a commit coincides.
//   data_out is stable while data_valid=1.
//  frame_abort has priority over bit_strobe in the same cycle. It resets the FSM and
//   counter only; the output register and data_valid are untouched.
//  cfg_* changes mid-frame take no effect until the next start bit.
//  Async reset mid-frame: immediate return to the reset values; no partial commit.
// CONFIGURATION
//  UART_DESER_PARITY_CHK_EN defined:
//   parity_err = ^{data,parity_bit} ^ par_odd when par_en, otherwise 0.
//  UART_DESER_PARITY_CHK_EN undefined:
//   the parity bit is consumed and discarded; parity_err is tied to 0; no XOR logic.
// STRUCTURE
//  uart_pkg: rx_state_e enum typedef (IDLE..STOP2) and localparam START_BIT_VAL=1'b0.
//  Sub-module uart_rx_out_reg: one-entry valid/ready holding register with overrun
//   detection. Parameter W = DATA_W+2 (data plus both error flags).
// TESTING (DATA_W=8)
//  Frame 0,A5 (LSB first),1; par_en=0, stop2=0; ready=1
//   -> data_out=8'hA5, data_valid=1 one clk after the stop strobe, framing_err=0.
//  par_en=1, odd=0, data 8'h03, parity bit=1, macro on
//   -> parity_err=1; repeat with parity bit=0 -> parity_err=0.
//  stop2=1, second stop bit=0, data 8'h5A
//   -> data_out=8'h5A, framing_err=1, FSM back in IDLE.
//  Two frames 8'h11 then 8'h22 with data_ready=0 throughout
//   -> data_out holds 8'h11; overrun pulses once at the 8'h22 stop strobe.
//  frame_abort asserted after 4 data bits, then a full frame 8'hC3
//   -> only 8'hC3 delivered; busy=0 the cycle after the abort.
//  Idle-line strobes with bit=1 x10, then rst_n low mid-frame
//   -> busy stays 0 during the idle strobes; after reset all outputs are 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART RX frame deserializer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP1  = 3'd3,
        STOP2  = 3'd4
    } rx_state_e;

    localparam logic START_BIT_VAL = 1'b0;

endpackage

// File: rtl/uart_rx_out_reg.sv
// One-entry valid/ready holding register with overrun detection.
// Latency: 1 clk from i_load_vld to o_vld.
// Backpressure: a load while full and not being drained is dropped and pulses o_overrun.
module uart_rx_out_reg #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load_vld,
    input  logic [W-1:0] i_load_dat,
    input  logic         i_rdy,
    output logic         o_vld,
    output logic [W-1:0] o_dat,
    output logic         o_overrun
);

    logic         r_vld;
    logic [W-1:0] r_dat;
    logic         r_overrun;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld     <= 1'b0;
            r_dat     <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (i_load_vld) begin
                // A drain in the same cycle frees the slot for the new frame.
                if (!r_vld || i_rdy) begin
                    r_vld <= 1'b1;
                    r_dat <= i_load_dat;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_vld && i_rdy) begin
                r_vld <= 1'b0;
            end
        end
    end

    assign o_vld     = r_vld;
    assign o_dat     = r_dat;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/uart_rx_frame_deserializer.sv
// UART RX frame sequencer: places strobed samples into start/data/parity/stop fields.
// Latency: frame presented 1 clk after the final stop strobe; parity checked only with UART_DESER_PARITY_CHK_EN.
// Backpressure: one-entry output register; a frame arriving while it is full and undrained is dropped (overrun).
module uart_rx_frame_deserializer
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_par_en,
    input  logic              cfg_par_odd,
    input  logic              cfg_stop2,
    input  logic              bit_strobe,
    input  logic              sampled_bit,
    input  logic              frame_abort,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              framing_err,
    output logic              parity_err,
    output logic              overrun,
    output logic              busy
);

    rx_state_e         r_state;
    rx_state_e         w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shreg;
    logic              r_par_en;
    logic              r_stop2;
    logic              r_stop_err;
    logic              w_last_data;
    logic              w_commit;
    logic              w_frame_err;
    logic              w_par_err;
    logic [DATA_W+1:0] w_out_dat;

    assign w_last_data = (r_cnt == CNT_W'(DATA_W - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        if (frame_abort) begin
            w_state_nxt = IDLE;
        end else if (bit_strobe) begin
            case (r_state)
                IDLE:    if (sampled_bit == START_BIT_VAL) w_state_nxt = DATA;
                DATA:    if (w_last_data) w_state_nxt = r_par_en ? PARITY : STOP1;
                PARITY:  w_state_nxt = STOP1;
                STOP1: begin
                    if (r_stop2) begin
                        w_state_nxt = STOP2;
                    end else begin
                        w_state_nxt = IDLE;
                        w_commit    = 1'b1;
                    end
                end
                STOP2: begin
                    w_state_nxt = IDLE;
                    w_commit    = 1'b1;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

`ifdef UART_DESER_PARITY_CHK_EN
    logic r_par_odd;
    logic r_par_bit;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_shreg    <= '0;
            r_par_en   <= 1'b0;
            r_stop2    <= 1'b0;
            r_stop_err <= 1'b0;
`ifdef UART_DESER_PARITY_CHK_EN
            r_par_odd  <= 1'b0;
            r_par_bit  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (frame_abort) begin
                r_cnt <= '0;
            end else if (bit_strobe) begin
                case (r_state)
                    IDLE: begin
                        if (sampled_bit == START_BIT_VAL) begin
                            r_cnt      <= '0;
                            r_par_en   <= cfg_par_en;
                            r_stop2    <= cfg_stop2;
                            r_stop_err <= 1'b0;
`ifdef UART_DESER_PARITY_CHK_EN
                            r_par_odd  <= cfg_par_odd;
`endif
                        end
                    end
                    DATA: begin
                        r_shreg <= {sampled_bit, r_shreg[DATA_W-1:1]};
                        r_cnt   <= w_last_data ? '0 : r_cnt + 1'b1;
                    end
`ifdef UART_DESER_PARITY_CHK_EN
                    PARITY: r_par_bit <= sampled_bit;
`endif
                    STOP1:  r_stop_err <= ~sampled_bit;
                    default: ;
                endcase
            end
        end
    end

    // Only a 0 can start a frame, so the start bit can never flag a framing error.
    assign w_frame_err = r_stop_err | ~sampled_bit;

`ifdef UART_DESER_PARITY_CHK_EN
    assign w_par_err = r_par_en & (^{r_shreg, r_par_bit} ^ r_par_odd);
`else
    logic w_unused_par_odd;
    assign w_unused_par_odd = cfg_par_odd;
    assign w_par_err        = 1'b0;
`endif

    uart_rx_out_reg #(
        .W (DATA_W + 2)
    ) u_out_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load_vld (w_commit),
        .i_load_dat ({w_par_err, w_frame_err, r_shreg}),
        .i_rdy      (data_ready),
        .o_vld      (data_valid),
        .o_dat      (w_out_dat),
        .o_overrun  (overrun)
    );

    assign data_out    = w_out_dat[DATA_W-1:0];
    assign framing_err = w_out_dat[DATA_W];
    assign parity_err  = w_out_dat[DATA_W+1];
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_frame_deserializer.sv
// Directed and randomized frames checked against a frame-level reference model.
// Latency: n/a. Backpressure: exercised through data_ready patterns.
module tb_uart_rx_frame_deserializer;

    logic       clk;
    logic       rst_n;
    logic       cfg_par_en;
    logic       cfg_par_odd;
    logic       cfg_stop2;
    logic       bit_strobe;
    logic       sampled_bit;
    logic       frame_abort;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       framing_err;
    logic       parity_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Reference model of the held output frame.
    logic       exp_vld = 1'b0;
    logic [7:0] exp_dat = 8'h00;
    logic       exp_fe  = 1'b0;
    logic       exp_pe  = 1'b0;
    logic       exp_ovr = 1'b0;

    uart_rx_frame_deserializer #(.DATA_W(8), .CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_par_en  (cfg_par_en),
        .cfg_par_odd (cfg_par_odd),
        .cfg_stop2   (cfg_stop2),
        .bit_strobe  (bit_strobe),
        .sampled_bit (sampled_bit),
        .frame_abort (frame_abort),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .framing_err (framing_err),
        .parity_err  (parity_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag);
        chk({tag, "_vld"}, data_valid, exp_vld);
        if (exp_vld) begin
            chk({tag, "_dat"}, data_out, exp_dat);
            chk({tag, "_fe"}, framing_err, exp_fe);
            chk({tag, "_pe"}, parity_err, exp_pe);
        end
        chk({tag, "_ovr"}, overrun, exp_ovr);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        bit_strobe  = 1'b1;
        sampled_bit = b;
        @(negedge clk);
        bit_strobe  = 1'b0;
        sampled_bit = 1'($urandom);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic po,
                              input logic pb, input logic s2en, input logic sb1,
                              input logic sb2, input logic rdy_last);
        logic lb;
        logic new_fe;
        logic new_pe;
        @(negedge clk);
        cfg_par_en  = pe;
        cfg_par_odd = po;
        cfg_stop2   = s2en;
        bit_strobe  = 1'b1;
        sampled_bit = 1'b0;
        @(negedge clk);
        bit_strobe  = 1'b0;
        {cfg_par_en, cfg_par_odd, cfg_stop2} = 3'($urandom);
        chk("busy_after_start", busy, 1'b1);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (pe) send_bit(pb);
        if (s2en) begin
            send_bit(sb1);
            lb = sb2;
        end else begin
            lb = sb1;
        end
        @(negedge clk);
        bit_strobe  = 1'b1;
        sampled_bit = lb;
        data_ready  = rdy_last;
        @(negedge clk);
        bit_strobe  = 1'b0;
        data_ready  = 1'b0;
        new_fe = !sb1 || (s2en && !sb2);
`ifdef UART_DESER_PARITY_CHK_EN
        new_pe = pe && ((($countones(d) + int'(pb)) % 2) != int'(po));
`else
        new_pe = 1'b0;
`endif
        exp_ovr = 1'b0;
        if (!exp_vld || rdy_last) begin
            exp_vld = 1'b1;
            exp_dat = d;
            exp_fe  = new_fe;
            exp_pe  = new_pe;
        end else begin
            exp_ovr = 1'b1;
        end
    endtask

    task automatic accept();
        @(negedge clk);
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        exp_vld = 1'b0;
        exp_ovr = 1'b0;
        chk("accept_vld", data_valid, 1'b0);
    endtask

    initial begin
        rst_n       = 1'b0;
        cfg_par_en  = 1'b0;
        cfg_par_odd = 1'b0;
        cfg_stop2   = 1'b0;
        bit_strobe  = 1'b0;
        sampled_bit = 1'b0;
        frame_abort = 1'b0;
        data_ready  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_vld", data_valid, 1'b0);
        chk("rst_dat", data_out, 8'h00);
        chk("rst_fe", framing_err, 1'b0);
        chk("rst_pe", parity_err, 1'b0);
        chk("rst_ovr", overrun, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;

        // Basic 8N1 frame with consumer ready; valid one clk after the stop strobe.
        chk("a5_pre_vld", data_valid, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk_out("a5");
        accept();

        // Even parity on 8'h03: parity bit 1 is wrong, 0 is right.
        send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk_out("par_bad");
        accept();
        send_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk_out("par_good");
        accept();

        // Two stop bits, second one low.
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_out("stop2_bad");
        accept();

        // Overrun: second frame is dropped while the first is held.
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk_out("ovr_first");
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk_out("ovr_second");
        @(negedge clk);
        exp_ovr = 1'b0;
        chk("ovr_pulse_end", overrun, 1'b0);
        chk("ovr_hold_dat", data_out, 8'h11);

        // Commit coinciding with acceptance replaces the held frame.
        send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk_out("coincide");

        // Abort after 4 data bits, strobe in the same cycle must be ignored.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom));
        @(negedge clk);
        frame_abort = 1'b1;
        bit_strobe  = 1'b1;
        sampled_bit = 1'b0;
        @(negedge clk);
        frame_abort = 1'b0;
        bit_strobe  = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_vld", data_valid, exp_vld);
        chk("abort_dat", data_out, exp_dat);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk_out("after_abort");
        accept();

        // Randomized frames with random configuration, line errors and consumer.
        for (int n = 0; n < 16; n++) begin
            logic [7:0] d;
            logic [6:0] r;
            d = 8'($urandom);
            r = 7'($urandom);
            send_frame(d, r[0], r[1], r[2], r[3], ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 3) != 0), r[4]);
            chk_out("rand");
            if (r[5] && exp_vld) accept();
        end

        // Idle-line strobes must not start a frame.
        for (int i = 0; i < 10; i++) begin
            send_bit(1'b1);
            chk("idle_busy", busy, 1'b0);
        end

        // Asynchronous reset mid-frame while a frame is held.
        if (!exp_vld) begin
            send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            chk_out("pre_reset");
        end
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_vld", data_valid, 1'b0);
        chk("arst_dat", data_out, 8'h00);
        chk("arst_fe", framing_err, 1'b0);
        chk("arst_pe", parity_err, 1'b0);
        chk("arst_ovr", overrun, 1'b0);
        chk("arst_busy", busy, 1'b0);
        exp_vld = 1'b0;
        exp_ovr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk_out("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
